// File: rtl/calculator_pkg.sv
// Shared calculator memory types: word geometry, arbiter state encoding and
// the default ownership burst length for the SRAM port arbiter.
package calculator_pkg;

  localparam int ADDR_W        = 9;
  localparam int MEM_WORD_SIZE = 64;
  localparam int ARB_MAX_BURST = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Ownership state for requester 'side' (0 -> OWN0, 1 -> OWN1).
  function automatic arb_state_e own_state(input logic side);
    return side ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the {sramB, sramA} 64b word memory between the
// calculator controller (m0) and the host loader/debug port (m1).
// One access per cycle; ownership is granted in bursts of up to MAX_BURST
// accesses and alternates round-robin when both sides want the memory.
// Optional feature macro: ARB_STATS_EN adds saturating per-requester
// accepted-access counters on stat_gnt0_o / stat_gnt1_o.
module sram_port_arbiter
  import calculator_pkg::*;
#(
  parameter int ADDR_W    = calculator_pkg::ADDR_W,
  parameter int DATA_W    = calculator_pkg::MEM_WORD_SIZE,
  parameter int MAX_BURST = calculator_pkg::ARB_MAX_BURST
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0_o,
  output logic [15:0]       stat_gnt1_o
`endif
);

  localparam int NREQ  = 2;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Requester fields gathered into packed per-port arrays so the owner mux
  // is a simple index by the owning side.
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             we;
  logic [NREQ-1:0][ADDR_W-1:0] addr;
  logic [NREQ-1:0][DATA_W-1:0] wdata;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rvalid_q;
  logic [NREQ-1:0][DATA_W-1:0] rdata;

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;     // 0: m0 wins a tie from IDLE
  logic [CNT_W-1:0] cnt_q, cnt_d;   // accepted accesses in current ownership

  logic own;                         // owning side when not IDLE
  logic owning;
  logic xfer;

  assign req   = {m1_req_i, m0_req_i};
  assign we    = {m1_we_i, m0_we_i};
  assign addr  = {m1_addr_i, m0_addr_i};
  assign wdata = {m1_wdata_i, m0_wdata_i};

  assign own    = (state_q == OWN1);
  assign owning = (state_q != IDLE);

  // Grant and read-return per requester; grants are exclusive by state.
  for (genvar n = 0; n < NREQ; n++) begin : g_port
    assign gnt[n]   = (state_q == own_state(1'(n))) && req[n];
    assign rdata[n] = rvalid_q[n] ? mem_rdata_i : '0;
  end

  assign xfer = |gnt;

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata[0];
  assign m1_rdata_o  = rdata[1];

  // Memory side: strobes only on a transfer; address/data follow the owner
  // and are forced to zero while nobody owns the memory (incl. reset).
  assign mem_write_o = xfer &  we[own];
  assign mem_read_o  = xfer & ~we[own];
  assign mem_waddr_o = owning ? addr[own]  : '0;
  assign mem_wdata_o = owning ? wdata[own] : '0;
  assign mem_raddr_o = owning ? addr[own]  : '0;

  // State, round-robin pointer and burst count registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: pick a side from IDLE, count accepted accesses while owning,
  // and hand over directly to a waiting requester without a bubble.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req[0] && req[1]) state_d = own_state(rr_q);
        else if (req[0])      state_d = OWN0;
        else if (req[1])      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!req[own]) begin
          // Owner went away: other side gets the memory next cycle if it asks.
          cnt_d   = '0;
          rr_d    = ~own;
          state_d = req[~own] ? own_state(~own) : IDLE;
        end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
          // This transfer completes a full burst.
          cnt_d = '0;
          if (req[~own]) begin
            rr_d    = ~own;
            state_d = own_state(~own);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read issuer tag: the requester that issued a read gets rvalid next cycle,
  // independent of who owns the memory by then.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rvalid_q <= '0;
    else        rvalid_q <= mem_read_o ? gnt : '0;
  end

`ifdef ARB_STATS_EN
  logic [NREQ-1:0][15:0] stat_q;

  // Saturating accepted-access counters, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_q <= '0;
    end else begin
      for (int n = 0; n < NREQ; n++)
        if (gnt[n] && (stat_q[n] != 16'hFFFF)) stat_q[n] <= stat_q[n] + 16'd1;
    end
  end

  assign stat_gnt0_o = stat_q[0];
  assign stat_gnt1_o = stat_q[1];
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a behavioural model of
// ownership, grants and a reference memory image.
module tb_sram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Requester-side drive (index 0 = m0, 1 = m1).
  logic          rq   [2];
  logic          rwe  [2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rwd  [2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]   stat0, stat1;
`endif

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(rq[0]), .m0_we_i(rwe[0]), .m0_addr_i(raddr[0]), .m0_wdata_i(rwd[0]),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(rq[1]), .m1_we_i(rwe[1]), .m1_addr_i(raddr[1]), .m1_wdata_i(rwd[1]),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_write_o(mem_write), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_read), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_gnt0_o(stat0), .stat_gnt1_o(stat1)
`endif
  );

  // Behavioural SRAM pair: registered read, write on the strobe.
  logic [DW-1:0] sram [512];
  logic          sram_init = 1'b0;

  function automatic logic [DW-1:0] init_word(input int i);
    return {16'hC0DE, 16'(i), 32'(i * 7 + 3)};
  endfunction

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 512; i++) sram[i] <= init_word(i);
    end else begin
      if (mem_write) sram[mem_waddr] <= mem_wdata;
      if (mem_read)  mem_rdata <= sram[mem_raddr];
    end
  end

  // Reference model state.
  int            m_own;      // -1 none, else owning requester
  int            m_rr;       // side preferred on a tie
  int            m_cnt;      // accesses accepted in current ownership
  bit            pv;         // read return pending
  int            pwho;
  logic [DW-1:0] pdata;
  logic [DW-1:0] ref_mem [512];
  int            acc [2];
  int            mode;       // 0 drop after transfer, 1 hold, 2 random

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_rr = 0; m_cnt = 0; pv = 0;
    acc[0] = 0; acc[1] = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    {m1_gnt, m0_gnt}, 0);
    chk({tag, "_rvalid"}, {m1_rvalid, m0_rvalid}, 0);
    chk({tag, "_rdata0"}, m0_rdata, 0);
    chk({tag, "_rdata1"}, m1_rdata, 0);
    chk({tag, "_strobes"}, {mem_write, mem_read}, 0);
    chk({tag, "_addr"},   {mem_waddr, mem_raddr}, 0);
    chk({tag, "_wdata"},  mem_wdata, 0);
  endtask

  task automatic new_req(input int n);
    rq[n]    = 1'b1;
    rwe[n]   = 1'($urandom_range(0, 1));
    raddr[n] = AW'($urandom_range(0, 15));
    rwd[n]   = {$urandom, $urandom};
  endtask

  // One clock: check DUT against the model, then advance model and drivers.
  task automatic cyc(output bit g0o, output bit g1o);
    bit e[2];
    int s;
    @(negedge clk);
    e[0] = (m_own == 0) && rq[0];
    e[1] = (m_own == 1) && rq[1];
    g0o = m0_gnt; g1o = m1_gnt;
    chk("gnt0", m0_gnt, e[0]);
    chk("gnt1", m1_gnt, e[1]);
    chk("rvalid0", m0_rvalid, pv && pwho == 0);
    chk("rvalid1", m1_rvalid, pv && pwho == 1);
    if (pv) chk("rdata", (pwho == 0) ? m0_rdata : m1_rdata, pdata);
    s = e[1] ? 1 : 0;
    if (e[0] || e[1]) begin
      chk("mem_write", mem_write, rwe[s]);
      chk("mem_read", mem_read, !rwe[s]);
      if (rwe[s]) begin
        chk("waddr", mem_waddr, raddr[s]);
        chk("wdata", mem_wdata, rwd[s]);
      end else begin
        chk("raddr", mem_raddr, raddr[s]);
      end
    end else begin
      chk("idle_strobes", {mem_write, mem_read}, 0);
    end
    @(posedge clk);
    pv = 0;
    if (e[0] || e[1]) begin
      acc[s]++;
      if (rwe[s]) ref_mem[raddr[s]] = rwd[s];
      else begin pv = 1; pwho = s; pdata = ref_mem[raddr[s]]; end
    end
    // Ownership rules.
    if (m_own < 0) begin
      if (rq[0] && rq[1]) m_own = m_rr;
      else if (rq[0])     m_own = 0;
      else if (rq[1])     m_own = 1;
      m_cnt = 0;
    end else if (!rq[m_own]) begin
      m_cnt = 0;
      m_rr  = 1 - m_own;
      m_own = rq[1 - m_own] ? 1 - m_own : -1;
    end else begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_cnt = 0;
        if (rq[1 - m_own]) begin m_own = 1 - m_own; m_rr = m_own; end
      end
    end
    #1;
    for (int n = 0; n < 2; n++) begin
      if (mode == 0) begin
        if (e[n]) rq[n] = 1'b0;
      end else if (mode == 2) begin
        if (e[n]) begin
          if ($urandom_range(0, 3) == 0) rq[n] = 1'b0; else new_req(n);
        end else if (!rq[n] && $urandom_range(0, 2) == 0) begin
          new_req(n);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) rq[n] = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  bit g0, g1;
  int cnt0;

  initial begin
    for (int n = 0; n < 2; n++) begin
      rq[n] = 1'b0; rwe[n] = 1'b0; raddr[n] = '0; rwd[n] = '0;
    end
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    model_reset();
    mode = 0;
    sram_init = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    sram_init = 1'b0;
    rst_n = 1'b1;

    // m0 write 0x005 <- 1: no grant on the first cycle, granted on the second.
    rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 9'h005; rwd[0] = 64'h1;
    cyc(g0, g1); chk("t1_latency", g0, 0);
    cyc(g0, g1); chk("t1_gnt", g0, 1);

    // m1 reads 0x005 back; model checks rdata against the written value.
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 9'h005;
    for (int c = 0; c < 6; c++) cyc(g0, g1);
    chk("t2_ref", ref_mem[5], 64'h1);

    // Both held from reset: bursts of MB alternate with no idle cycle.
    do_reset();
    mode = 1;
    rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 9'h010; rwd[0] = 64'hAAAA;
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 9'h011;
    for (int c = 0; c < 17; c++) begin
      cyc(g0, g1);
      if (c == 0) chk("t3_first", {g1, g0}, 0);
      else chk("t3_alt", {g1, g0}, (((c - 1) / MB) % 2 == 0) ? 2'b01 : 2'b10);
    end

    // m0 alone for 40 cycles: granted on every cycle after the first.
    do_reset();
    mode = 1;
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 9'h007;
    cnt0 = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(g0, g1);
      cnt0 += int'(g0);
    end
    chk("t4_grants", 32'(cnt0), 32'd39);

    // Reset in the middle of an m1 read burst.
    do_reset();
    mode = 1;
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 9'h003;
    for (int c = 0; c < 4; c++) cyc(g0, g1);
    chk("t5_rvalid_before", m1_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cyc(g0, g1);

`ifdef ARB_STATS_EN
    do_reset();
    mode = 1;
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 9'h001;
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 9'h002;
    for (int c = 0; c < 20; c++) cyc(g0, g1);
    chk("t6_stat_sum", 32'(stat0) + 32'(stat1), 32'd19);
    chk("t6_stat0", 32'(stat0), 32'(acc[0]));
`endif

    // Randomized traffic.
    do_reset();
    mode = 2;
    for (int c = 0; c < 600; c++) begin
      cyc(g0, g1);
      if (c == 300) begin
        mode = 0;
        for (int k = 0; k < 3; k++) cyc(g0, g1);
        mode = 2;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
